// File: rtl/distance_pkg.sv
// Shared types and constants for the new_average_distance interface,
// used by both the distance averager and the consumer pulse generator.
package distance_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam int AVG_BUS_WIDTH  = 32;
  localparam int DEF_N_SAMPLES  = 4;
  localparam int DEF_LOG2_N     = 2;
  localparam int DEF_DIST_WIDTH = 16;

endpackage

// File: rtl/distance_averager.sv
// Averages windows of N_SAMPLES distance measurements and presents the
// truncated mean (never zero) on a bus that otherwise reads zero, so a
// downstream rising-edge detector sees one edge per completed window.
module distance_averager
  import distance_pkg::*;
#(
  parameter int N_SAMPLES  = DEF_N_SAMPLES,
  parameter int LOG2_N     = DEF_LOG2_N,
  parameter int DIST_WIDTH = DEF_DIST_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     medida_pronta,
  input  logic [DIST_WIDTH-1:0]    distancia,
  output logic [AVG_BUS_WIDTH-1:0] new_average_distance,
  output logic                     busy,
  output logic [7:0]               windows_done
);

  // Wide enough for the sum of a full window, so it cannot overflow.
  localparam int ACC_W = DIST_WIDTH + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_SAMPLES - 1);

  if (((1 << LOG2_N) != N_SAMPLES) || (N_SAMPLES < 2)) begin : g_bad_params
    $error("distance_averager: N_SAMPLES must be a power of two >= 2 and equal 2**LOG2_N");
  end

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ACC_W-1:0]         r_acc;
  logic [ACC_W-1:0]         w_acc_nxt;
  logic [ACC_W-1:0]         w_sum;
  logic [LOG2_N-1:0]        r_count;
  logic [LOG2_N-1:0]        w_count_nxt;
  logic [AVG_BUS_WIDTH-1:0] r_avg;
  logic [AVG_BUS_WIDTH-1:0] w_avg_nxt;
  logic [7:0]               r_windows;
  logic [7:0]               w_windows_nxt;
  logic                     r_busy;

  // Truncated mean, zero-extended; a zero mean becomes 1 so the consumer
  // still sees a rising edge for the window.
  function automatic logic [AVG_BUS_WIDTH-1:0] window_mean(input logic [ACC_W-1:0] sum);
    logic [AVG_BUS_WIDTH-1:0] mean;
    mean = AVG_BUS_WIDTH'(sum >> LOG2_N);
    if (mean == '0) mean = AVG_BUS_WIDTH'(1);
    return mean;
  endfunction

  assign w_sum = r_acc + ACC_W'(distancia);

  // Next-state and next-datapath decode; clear overrides any strobe.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_count_nxt   = r_count;
    w_avg_nxt     = r_avg;
    w_windows_nxt = r_windows;
    if (clear) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_count_nxt = '0;
      w_avg_nxt   = '0;
    end else if (medida_pronta) begin
      case (r_state)
        IDLE, PRESENT: begin
          w_state_nxt = ACCUM;
          w_acc_nxt   = ACC_W'(distancia);
          w_count_nxt = LOG2_N'(1);
          w_avg_nxt   = '0;
        end
        ACCUM: begin
          w_acc_nxt   = w_sum;
          w_count_nxt = r_count + LOG2_N'(1);
          if (r_count == LAST_IDX) begin
            w_avg_nxt     = window_mean(w_sum);
            w_windows_nxt = r_windows + 8'd1;
            w_state_nxt   = PRESENT;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
          w_count_nxt = '0;
          w_avg_nxt   = '0;
        end
      endcase
    end
  end

  // State, accumulator, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_count   <= '0;
      r_avg     <= '0;
      r_windows <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_count   <= w_count_nxt;
      r_avg     <= w_avg_nxt;
      r_windows <= w_windows_nxt;
      r_busy    <= (w_state_nxt == ACCUM);
    end
  end

  assign new_average_distance = r_avg;
  assign busy                 = r_busy;
  assign windows_done         = r_windows;

endmodule

// File: tb/tb_distance_averager.sv
// Directed bench for distance_averager with hand-computed expectations.
module tb_distance_averager;
  import distance_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        medida_pronta = 1'b0;
  logic [15:0] distancia = '0;
  logic [31:0] new_average_distance;
  logic        busy;
  logic [7:0]  windows_done;

  int vectors = 0;
  int miscompares = 0;

  distance_averager #(.N_SAMPLES(4), .LOG2_N(2), .DIST_WIDTH(16)) dut (
    .clock                (clock),
    .reset                (reset),
    .clear                (clear),
    .medida_pronta        (medida_pronta),
    .distancia            (distancia),
    .new_average_distance (new_average_distance),
    .busy                 (busy),
    .windows_done         (windows_done)
  );

  always #5 clock = ~clock;

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic s, input logic [15:0] d, input logic c);
    medida_pronta = s;
    distancia     = d;
    clear         = c;
    @(posedge clock);
    #1;
    medida_pronta = 1'b0;
    clear         = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_bus", new_average_distance, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_windows", {24'd0, windows_done}, 32'd0);

    // Basic average: 100,200,300,400 -> 250
    cyc(1, 16'd100, 0);
    chk("basic_bus1", new_average_distance, 32'd0);
    chk("basic_busy1", {31'd0, busy}, 32'd1);
    cyc(1, 16'd200, 0);
    cyc(1, 16'd300, 0);
    chk("basic_bus3", new_average_distance, 32'd0);
    cyc(1, 16'd400, 0);
    chk("basic_avg", new_average_distance, 32'd250);
    chk("basic_windows", {24'd0, windows_done}, 32'd1);
    chk("basic_busy", {31'd0, busy}, 32'd0);
    cyc(0, 16'd0, 0);
    cyc(0, 16'd0, 0);
    chk("basic_hold", new_average_distance, 32'd250);

    // Back-to-back windows: 10 x4 then 20 x4
    repeat (3) cyc(1, 16'd10, 0);
    chk("b2b_first_zero", new_average_distance, 32'd0);
    cyc(1, 16'd10, 0);
    chk("b2b_avg10", new_average_distance, 32'd10);
    chk("b2b_win2", {24'd0, windows_done}, 32'd2);
    cyc(1, 16'd20, 0);
    chk("b2b_gap", new_average_distance, 32'd0);
    chk("b2b_gap_busy", {31'd0, busy}, 32'd1);
    cyc(1, 16'd20, 0);
    cyc(1, 16'd20, 0);
    chk("b2b_gap3", new_average_distance, 32'd0);
    cyc(1, 16'd20, 0);
    chk("b2b_avg20", new_average_distance, 32'd20);
    chk("b2b_win3", {24'd0, windows_done}, 32'd3);

    // Zero clamp: 0,0,0,1 -> mean 0 -> 1
    cyc(1, 16'd0, 0);
    chk("clamp_zero_bus", new_average_distance, 32'd0);
    cyc(1, 16'd0, 0);
    cyc(1, 16'd0, 0);
    cyc(1, 16'd1, 0);
    chk("clamp_avg", new_average_distance, 32'd1);
    chk("clamp_win", {24'd0, windows_done}, 32'd4);

    // Truncation: 1,2,2,2 -> 7>>2 = 1
    cyc(1, 16'd1, 0);
    cyc(1, 16'd2, 0);
    cyc(1, 16'd2, 0);
    cyc(1, 16'd2, 0);
    chk("trunc_avg", new_average_distance, 32'd1);

    // Max value: four 0xFFFF -> 0xFFFF
    repeat (4) cyc(1, 16'hFFFF, 0);
    chk("max_avg", new_average_distance, 32'h0000FFFF);
    chk("max_win", {24'd0, windows_done}, 32'd6);

    // Clear priority: two samples, then clear with a strobe, then 40 x4
    cyc(1, 16'd5, 0);
    cyc(1, 16'd7, 0);
    cyc(1, 16'd1000, 1);
    chk("clear_bus", new_average_distance, 32'd0);
    chk("clear_busy", {31'd0, busy}, 32'd0);
    chk("clear_win", {24'd0, windows_done}, 32'd6);
    repeat (3) cyc(1, 16'd40, 0);
    chk("clear_bus3", new_average_distance, 32'd0);
    cyc(1, 16'd40, 0);
    chk("clear_avg", new_average_distance, 32'd40);
    chk("clear_win7", {24'd0, windows_done}, 32'd7);

    // Asynchronous reset mid-window
    repeat (3) cyc(1, 16'd9, 0);
    chk("arst_pre_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_bus", new_average_distance, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_win", {24'd0, windows_done}, 32'd0);
    #2 reset = 1'b0;
    repeat (3) cyc(1, 16'd8, 0);
    chk("arst_fresh3", new_average_distance, 32'd0);
    cyc(1, 16'd8, 0);
    chk("arst_avg", new_average_distance, 32'd8);
    chk("arst_win1", {24'd0, windows_done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
